mod_pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the MIPS core. It holds the architectural PC, drives pc_plus_4 to the next-PC selection mux, and loads the mux's next_pc result. It runs one request/response transaction per instruction on the instruction-memory port and presents each fetched word to decode with a valid/stall handshake. It also detects misaligned fetch addresses and keeps a free-running count of fetched instructions.

---
 rtl/mod_pc_fetch.sv | 114 +++++++++++
 tb/tb_mod_pc_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_pc_fetch.sv
`default_nettype none
// ============================================================================
// mod_pc_fetch : PC register and instruction-fetch sequencer with handoff
// Rev 1.0
// ============================================================================
module mod_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fetch_fault;
  logic [31:0] r_fetch_count;

  logic        w_req;
  logic        w_load_instr;
  logic        w_handoff;
  logic        w_set_fault;

  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_load_instr = 1'b0;
    w_handoff    = 1'b0;
    w_set_fault  = 1'b0;
    case (r_state)
      S_REQ: begin
        // A misaligned PC never reaches the memory port.
        if (r_pc[1:0] != 2'b00) begin
          w_set_fault = 1'b1;
          w_state_nxt = S_FAULT;
        end else begin
          w_req = 1'b1;
          if (imem_gnt) w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_instr) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_handoff) begin
        r_pc          <= next_pc;
        r_fetch_count <= r_fetch_count + 32'd1;
        r_instr_valid <= 1'b0;
      end
      if (w_set_fault) r_fetch_fault <= 1'b1;
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus_4   = r_pc + 32'd4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_mod_pc_fetch.sv
`default_nettype none
// ============================================================================
// tb_mod_pc_fetch : directed and randomized fetch transactions vs. a
// transaction-level model of PC, fetch count and per-phase cycle timing.
// Rev 1.0
// ============================================================================
module tb_mod_pc_fetch;

  logic        clk;
  logic        reset_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  mod_pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .next_pc    (next_pc),
    .stall      (stall),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete instruction: gd cycles of withheld grant, rd cycles of
  // withheld rvalid, sd cycles of stall in hold, then handoff to npc.
  // Ignored inputs (gnt outside request, rvalid outside wait, stall outside
  // hold, next_pc outside handoff) are driven with random noise.
  task automatic do_fetch(input int gd, input int rd, input int sd,
                          input logic [31:0] npc, input logic [31:0] data);
    for (int i = 0; i <= gd; i++) begin
      check("req_phase_req", {31'd0, imem_req}, 32'd1);
      check("req_phase_addr", imem_addr, exp_pc);
      check("req_phase_pc4", pc_plus_4, exp_pc + 32'd4);
      check("req_phase_valid", {31'd0, instr_valid}, 32'd0);
      check("req_phase_count", fetch_count, exp_count);
      imem_gnt    = (i == gd);
      imem_rvalid = 1'($urandom());
      imem_rdata  = $urandom();
      stall       = 1'($urandom());
      next_pc     = $urandom();
      step();
    end
    for (int j = 0; j <= rd; j++) begin
      check("wait_phase_req", {31'd0, imem_req}, 32'd0);
      check("wait_phase_valid", {31'd0, instr_valid}, 32'd0);
      check("wait_phase_pc", pc, exp_pc);
      imem_gnt    = 1'($urandom());
      imem_rvalid = (j == rd);
      imem_rdata  = (j == rd) ? data : $urandom();
      stall       = 1'($urandom());
      next_pc     = $urandom();
      step();
    end
    for (int k = 0; k <= sd; k++) begin
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, data);
      check("hold_pc", pc, exp_pc);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_count", fetch_count, exp_count);
      imem_gnt    = 1'($urandom());
      imem_rvalid = 1'($urandom());
      imem_rdata  = $urandom();
      stall       = (k < sd);
      next_pc     = (k == sd) ? npc : $urandom();
      step();
    end
    exp_pc    = npc;
    exp_count = exp_count + 32'd1;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    step();
    step();
    reset_n   = 1'b1;
    exp_pc    = 32'h0000_0000;
    exp_count = 32'h0000_0000;
  endtask

  initial begin
    logic [31:0] rnd_pc;
    reset_n     = 1'b0;
    next_pc     = 32'h0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    exp_pc      = 32'h0;
    exp_count   = 32'h0;

    apply_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);

    // Sequential fetch 0,4,8 then jump to 0x100.
    do_fetch(0, 0, 0, 32'h4, 32'h1111_0000);
    do_fetch(0, 0, 0, 32'h8, 32'h1111_0004);
    do_fetch(0, 0, 0, 32'h100, 32'h1111_0008);
    check("seq_count3", fetch_count, 32'd3);
    check("jump_addr", imem_addr, 32'h100);
    check("jump_pc4", pc_plus_4, 32'h104);

    // Stall held four cycles in hold.
    do_fetch(0, 0, 4, 32'h104, 32'h2402_0005);
    check("stall_count", fetch_count, 32'd4);

    // Grant delayed 3, rvalid delayed 2: valid 7 cycles after first request.
    do_fetch(3, 2, 0, 32'h108, 32'hDEAD_BEEF);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      rnd_pc = $urandom();
      rnd_pc[1:0] = 2'b00;
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), rnd_pc, $urandom());
    end

    // PC at top of address space wraps pc_plus_4.
    do_fetch(0, 1, 0, 32'hFFFF_FFFC, 32'h0BAD_F00D);
    check("wrap_pc4", pc_plus_4, 32'h0000_0000);
    do_fetch(1, 0, 1, 32'h0000_0200, 32'h1234_5678);

    // Misaligned handoff target: no request, sticky fault, frozen PC.
    do_fetch(0, 0, 0, 32'h102, 32'hCAFE_0001);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_fault_pre", {31'd0, fetch_fault}, 32'd0);
    step();
    for (int m = 0; m < 5; m++) begin
      check("fault_flag", {31'd0, fetch_fault}, 32'd1);
      check("fault_req", {31'd0, imem_req}, 32'd0);
      check("fault_valid", {31'd0, instr_valid}, 32'd0);
      check("fault_pc", pc, 32'h102);
      imem_gnt    = 1'($urandom());
      imem_rvalid = 1'($urandom());
      stall       = 1'($urandom());
      next_pc     = $urandom();
      step();
    end
    apply_reset();
    check("fault_rst_pc", pc, 32'h0);
    check("fault_rst_flag", {31'd0, fetch_fault}, 32'd0);
    check("fault_rst_req", {31'd0, imem_req}, 32'd1);

    // Reset while waiting for a response.
    do_fetch(0, 0, 0, 32'h40, 32'h0000_0001);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("wait_before_rst", {31'd0, imem_req}, 32'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_req", {31'd0, imem_req}, 32'd1);
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    do_fetch(0, 0, 0, 32'h4, 32'h5555_AAAA);
    check("post_rst_count", fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
